// File: rtl/fma16_arb.sv
// fma16_arb: round-robin front end sharing one half-precision fma16 datapath.
// Ports: req_* valid/ready per requester, rsp_* valid/ready out, per-requester sticky fflags.
module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  rm,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  // result = (-1)^negp * x * (mul ? y : 1) + (-1)^negz * (add ? z : 0)
  // rm: 00 rtz, 01 rne, 10 rdn, 11 rup.  flags = {nv, of, uf, nx}
  localparam int W = 82;

  function automatic logic is_nan(input logic [15:0] v);
    return (&v[14:10]) & (|v[9:0]);
  endfunction
  function automatic logic is_snan(input logic [15:0] v);
    return is_nan(v) & ~v[9];
  endfunction
  function automatic logic is_inf(input logic [15:0] v);
    return (&v[14:10]) & ~(|v[9:0]);
  endfunction
  function automatic logic is_zero(input logic [15:0] v);
    return ~(|v[14:0]);
  endfunction
  function automatic logic [10:0] sig(input logic [15:0] v);
    return {|v[14:10], v[9:0]};
  endfunction
  function automatic int expo(input logic [15:0] v);
    return (v[14:10] == 5'd0) ? 1 : int'(v[14:10]);
  endfunction

  logic [15:0]  ye, ze;
  logic         sp, sz, sgn;
  logic         anynan, inv, pinf, zinf;
  logic [21:0]  prod;
  logic [W-1:0] pmag, zmag, mag;
  logic [6:0]   lead, lsb;
  logic [10:0]  kept;
  logic         g, st, inc, inx, ovf, tiny, big;
  logic [16:0]  ebits, enc;

  always_comb begin
    ye     = mul ? y : 16'h3C00;
    ze     = add ? z : 16'h0000;
    sp     = x[15] ^ ye[15] ^ negp;
    // a missing addend is a zero of the product's sign
    sz     = add ? (z[15] ^ negz) : sp;
    anynan = is_nan(x) | is_nan(ye) | is_nan(ze);
    pinf   = is_inf(x) | is_inf(ye);
    zinf   = is_inf(ze);
    inv    = is_snan(x) | is_snan(ye) | is_snan(ze)
           | (is_inf(x) & is_zero(ye))
           | (is_zero(x) & is_inf(ye))
           | (pinf & zinf & (sp != sz) & ~anynan);

    // exact fixed point, LSB weight 2^-48
    prod = {11'b0, sig(x)} * {11'b0, sig(ye)};
    pmag = {60'b0, prod} << (expo(x) + expo(ye) - 2);
    zmag = {71'b0, sig(ze)} << (expo(ze) + 23);

    if (sp == sz) begin
      mag = pmag + zmag;
      sgn = sp;
    end else if (pmag >= zmag) begin
      mag = pmag - zmag;
      sgn = sp;
    end else begin
      mag = zmag - pmag;
      sgn = sz;
    end
    if (mag == '0 && sp != sz) sgn = (rm == 2'b10);

    lead = 7'd0;
    for (int i = 0; i < W; i++)
      if (mag[i]) lead = 7'(i);

    // bit 34 carries weight 2^-14; below it the LSB pins at 2^-24
    lsb   = (lead >= 7'd34) ? lead - 7'd10 : 7'd24;
    kept  = 11'(mag >> lsb);
    g     = mag[lsb - 7'd1];
    st    = |(mag & ((W'(1) << (lsb - 7'd1)) - W'(1)));
    inx   = g | st;
    tiny  = lead < 7'd34;

    case (rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = g & (st | kept[0]);
      2'b10:   inc = inx & sgn;
      default: inc = inx & ~sgn;
    endcase

    // mantissa carry on rounding flows straight into the exponent field
    ebits = (lead >= 7'd34) ? 17'(lead - 7'd33) : 17'd0;
    enc   = (ebits << 10) + {7'b0, kept[9:0]} + {16'b0, inc};
    ovf   = enc >= 17'h07C00;

    case (rm)
      2'b00:   big = 1'b0;
      2'b01:   big = 1'b1;
      2'b10:   big = sgn;
      default: big = ~sgn;
    endcase

    if (anynan | inv) begin
      result = 16'h7E00;
      flags  = {inv, 3'b000};
    end else if (pinf | zinf) begin
      result = {pinf ? sp : sz, 15'h7C00};
      flags  = 4'b0000;
    end else if (ovf) begin
      result = {sgn, big ? 15'h7C00 : 15'h7BFF};
      flags  = 4'b0101;
    end else begin
      result = {sgn, enc[14:0]};
      flags  = {2'b00, tiny & inx, inx};
    end
  end
endmodule

module fma16_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*16-1:0]   req_x,
  input  logic [NREQ*16-1:0]   req_y,
  input  logic [NREQ*16-1:0]   req_z,
  input  logic [NREQ-1:0]      req_mul,
  input  logic [NREQ-1:0]      req_add,
  input  logic [NREQ-1:0]      req_negp,
  input  logic [NREQ-1:0]      req_negz,
  input  logic [2*NREQ-1:0]    req_rm,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  input  logic [NREQ-1:0]      clr_flags,
  output logic [4*NREQ-1:0]    sticky_flags
);
  localparam int FLEN = 16;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [FLEN-1:0] x;
    logic [FLEN-1:0] y;
    logic [FLEN-1:0] z;
    logic            mul;
    logic            add;
    logic            negp;
    logic            negz;
    logic [1:0]      rm;
  } s1_t;

  logic            s1_valid_q, s1_valid_d;
  s1_t             s1_q, s1_d;
  logic            s2_valid_q, s2_valid_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [FLEN-1:0] s2_res_q, s2_res_d;
  logic [3:0]      s2_flg_q, s2_flg_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [4*NREQ-1:0] sticky_q, sticky_d;

  logic            s2_free, s1_move, s1_free;
  logic            gnt_any, accept;
  logic [IDW-1:0]  gnt_id;
  int              gidx, g;
  logic [FLEN-1:0] fma_res;
  logic [3:0]      fma_flg;

  assign s2_free = ~s2_valid_q | rsp_ready;
  assign s1_move = s1_valid_q & s2_free;
  assign s1_free = ~s1_valid_q | s1_move;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    gidx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      gidx = int'(rr_q) + k;
      if (gidx >= NREQ) gidx = gidx - NREQ;
      if (!gnt_any && req_valid[gidx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(gidx);
      end
    end
  end

  assign accept = gnt_any & s1_free;

  always_comb begin
    req_ready = '0;
    if (accept && reset_n) req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    g          = int'(gnt_id);
    rr_d       = rr_q;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (accept) begin
      rr_d       = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      s1_valid_d = 1'b1;
      s1_d.id    = gnt_id;
      s1_d.x     = req_x[g*FLEN +: FLEN];
      s1_d.y     = req_y[g*FLEN +: FLEN];
      s1_d.z     = req_z[g*FLEN +: FLEN];
      s1_d.mul   = req_mul[g];
      s1_d.add   = req_add[g];
      s1_d.negp  = req_negp[g];
      s1_d.negz  = req_negz[g];
      s1_d.rm    = req_rm[g*2 +: 2];
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  fma16 u_fma (
    .x      (s1_q.x),
    .y      (s1_q.y),
    .z      (s1_q.z),
    .mul    (s1_q.mul),
    .add    (s1_q.add),
    .negp   (s1_q.negp),
    .negz   (s1_q.negz),
    .rm     (s1_q.rm),
    .result (fma_res),
    .flags  (fma_flg)
  );

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_res_d   = s2_res_q;
    s2_flg_d   = s2_flg_q;
    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_id_d    = s1_q.id;
      s2_res_d   = fma_res;
      s2_flg_d   = fma_flg;
    end else if (rsp_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // clear first, then OR-in: a same-cycle clear leaves exactly the new flags
  always_comb begin
    sticky_d = sticky_q;
    for (int i = 0; i < NREQ; i++) begin
      if (clr_flags[i]) sticky_d[4*i +: 4] = 4'b0000;
      if (s1_move && int'(s1_q.id) == i)
        sticky_d[4*i +: 4] = sticky_d[4*i +: 4] | fma_flg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_res_q   <= '0;
      s2_flg_q   <= '0;
      rr_q       <= '0;
      sticky_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_res_q   <= s2_res_d;
      s2_flg_q   <= s2_flg_d;
      rr_q       <= rr_d;
      sticky_q   <= sticky_d;
    end
  end

  assign rsp_valid    = s2_valid_q;
  assign rsp_id       = s2_id_q;
  assign rsp_result   = s2_res_q;
  assign rsp_flags    = s2_flg_q;
  assign sticky_flags = sticky_q;
endmodule

// File: tb/tb_fma16_arb.sv
// tb_fma16_arb: directed bench for fma16_arb with two requesters.
// Drives after posedge+1, samples at posedge+1/+2, reports one summary line.
module tb_fma16_arb;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready;
  logic [31:0] req_x, req_y, req_z;
  logic [1:0]  req_mul, req_add, req_negp, req_negz;
  logic [3:0]  req_rm;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [1:0]  clr_flags;
  logic [7:0]  sticky_flags;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fma16_arb #(.NREQ(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_z        (req_z),
    .req_mul      (req_mul),
    .req_add      (req_add),
    .req_negp     (req_negp),
    .req_negz     (req_negz),
    .req_rm       (req_rm),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .clr_flags    (clr_flags),
    .sticky_flags (sticky_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] x, y, z,
                         input logic mul, add, negp, negz,
                         input logic [1:0] rm);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    req_z[i*16 +: 16] = z;
    req_mul[i]        = mul;
    req_add[i]        = add;
    req_negp[i]       = negp;
    req_negz[i]       = negz;
    req_rm[i*2 +: 2]  = rm;
  endtask

  task automatic do_reset;
    req_valid = 2'b00;
    clr_flags = 2'b00;
    rsp_ready = 1'b1;
    #1 reset_n = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask

  // one op through requester r on an idle pipeline
  task automatic run_vec(input string tag, input int r,
                         input logic [15:0] x, y, z,
                         input logic mul, add, negp, negz,
                         input logic [1:0] rm,
                         input logic [15:0] er, input logic [3:0] ef);
    int n;
    set_req(r, x, y, z, mul, add, negp, negz, rm);
    req_valid = 2'(1 << r);
    #1;
    chk({tag, "_rdy"}, {30'b0, req_ready}, 32'(1 << r));
    tick;
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid && n < 10) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, 1);
    chk({tag, "_vld"}, {31'b0, rsp_valid}, 1);
    chk({tag, "_id"}, {31'b0, rsp_id}, r);
    chk({tag, "_res"}, {16'b0, rsp_result}, {16'b0, er});
    chk({tag, "_flg"}, {28'b0, rsp_flags}, {28'b0, ef});
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    clr_flags = 2'b00;
    req_x = '0; req_y = '0; req_z = '0;
    req_mul = '0; req_add = '0; req_negp = '0; req_negz = '0;
    req_rm = '0;

    // reset state, with requests pending
    #2 reset_n = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_ready", {30'b0, req_ready}, 0);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_id", {31'b0, rsp_id}, 0);
    chk("rst_res", {16'b0, rsp_result}, 0);
    chk("rst_flg", {28'b0, rsp_flags}, 0);
    chk("rst_sticky", {24'b0, sticky_flags}, 0);

    // single-op latency
    do_reset;
    set_req(0, 16'h3C00, 16'h3C00, 16'h3C00, 1, 1, 0, 0, 2'd0);
    req_valid = 2'b01;
    #1;
    chk("lat_rdy", {30'b0, req_ready}, 2'b01);
    tick;
    req_valid = 2'b00;
    chk("lat_n1", {31'b0, rsp_valid}, 0);
    tick;
    chk("lat_vld", {31'b0, rsp_valid}, 1);
    chk("lat_id", {31'b0, rsp_id}, 0);
    chk("lat_res", {16'b0, rsp_result}, 32'h4000);
    chk("lat_flg", {28'b0, rsp_flags}, 0);
    tick;
    chk("lat_once", {31'b0, rsp_valid}, 0);

    // datapath vectors: rm 0 rtz, 1 rne, 2 rdn, 3 rup
    run_vec("sub", 0, 16'h4000, 16'h3C00, 16'h3C00, 1, 1, 0, 1, 2'd0,
            16'h3C00, 4'b0000);
    run_vec("zero", 0, 16'h3C00, 16'h3C00, 16'hBC00, 1, 1, 0, 0, 2'd0,
            16'h0000, 4'b0000);
    run_vec("ovf_rne", 0, 16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'd1,
            16'h7C00, 4'b0101);
    run_vec("ovf_rtz", 0, 16'h7BFF, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'd0,
            16'h7BFF, 4'b0101);
    run_vec("uf_rne", 0, 16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, 2'd1,
            16'h0000, 4'b0011);
    run_vec("uf_rup", 0, 16'h0001, 16'h3800, 16'h0000, 1, 0, 0, 0, 2'd3,
            16'h0001, 4'b0011);
    run_vec("qnan", 0, 16'h7E00, 16'h3C00, 16'h0000, 1, 0, 0, 0, 2'd1,
            16'h7E00, 4'b0000);
    run_vec("snan", 0, 16'h7C01, 16'h3C00, 16'h0000, 1, 0, 0, 0, 2'd1,
            16'h7E00, 4'b1000);
    run_vec("infinf", 0, 16'h7C00, 16'h3C00, 16'hFC00, 1, 1, 0, 0, 2'd1,
            16'h7E00, 4'b1000);

    // contention: 1*2 from requester 0, 2*2 from requester 1
    do_reset;
    set_req(0, 16'h3C00, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'd0);
    set_req(1, 16'h4000, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'd0);
    for (int c = 0; c < 6; c++) begin
      req_valid = (c < 4) ? 2'b11 : 2'b00;
      #1;
      if (c < 4)
        chk($sformatf("cont_rdy%0d", c), {30'b0, req_ready},
            (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c >= 2) begin
        chk($sformatf("cont_vld%0d", c), {31'b0, rsp_valid}, 1);
        chk($sformatf("cont_id%0d", c), {31'b0, rsp_id}, (c - 2) % 2);
        chk($sformatf("cont_res%0d", c), {16'b0, rsp_result},
            (c % 2 == 0) ? 32'h4000 : 32'h4400);
      end
      tick;
    end
    chk("cont_drain", {31'b0, rsp_valid}, 0);

    // backpressure: fill both stages, stall three cycles
    do_reset;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 2'b11;
      #1;
      if (c == 0) chk("bp_rdy0", {30'b0, req_ready}, 2'b01);
      if (c == 1) chk("bp_rdy1", {30'b0, req_ready}, 2'b10);
      if (c >= 2) begin
        chk($sformatf("bp_full%0d", c), {30'b0, req_ready}, 0);
        chk($sformatf("bp_vld%0d", c), {31'b0, rsp_valid}, 1);
        chk($sformatf("bp_id%0d", c), {31'b0, rsp_id}, 0);
        chk($sformatf("bp_hold%0d", c), {16'b0, rsp_result}, 32'h4000);
      end
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    #1;
    chk("bp_a_vld", {31'b0, rsp_valid}, 1);
    chk("bp_a_res", {16'b0, rsp_result}, 32'h4000);
    tick;
    chk("bp_b_vld", {31'b0, rsp_valid}, 1);
    chk("bp_b_id", {31'b0, rsp_id}, 1);
    chk("bp_b_res", {16'b0, rsp_result}, 32'h4400);
    tick;
    chk("bp_empty", {31'b0, rsp_valid}, 0);

    // sticky flags
    do_reset;
    run_vec("stk0", 0, 16'h3C01, 16'h3C01, 16'h0000, 1, 0, 0, 0, 2'd0,
            16'h3C02, 4'b0001);
    chk("stk_s0", {24'b0, sticky_flags}, 32'h01);
    run_vec("stk1", 1, 16'h7C00, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'd1,
            16'h7E00, 4'b1000);
    chk("stk_s1", {24'b0, sticky_flags}, 32'h81);
    clr_flags = 2'b10;
    tick;
    clr_flags = 2'b00;
    chk("stk_clr", {24'b0, sticky_flags}, 32'h01);

    // clear and set to slice 1 in the same cycle
    do_reset;
    set_req(1, 16'h7C00, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'd1);
    req_valid = 2'b10;
    #1;
    tick;
    req_valid = 2'b00;
    clr_flags = 2'b10;
    tick;
    clr_flags = 2'b00;
    chk("col_flg", {28'b0, rsp_flags}, 32'h8);
    chk("col_sticky", {24'b0, sticky_flags}, 32'h80);

    // reset with both stages occupied, rr left pointing at 1
    do_reset;
    rsp_ready = 1'b0;
    set_req(1, 16'h7C00, 16'h0000, 16'h0000, 1, 0, 0, 0, 2'd1);
    set_req(0, 16'h3C00, 16'h4000, 16'h0000, 1, 0, 0, 0, 2'd0);
    req_valid = 2'b10;
    #1;
    tick;
    req_valid = 2'b01;
    #1;
    chk("mid_rdy", {30'b0, req_ready}, 2'b01);
    tick;
    req_valid = 2'b11;
    chk("mid_vld", {31'b0, rsp_valid}, 1);
    chk("mid_sticky", {24'b0, sticky_flags}, 32'h80);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_vld", {31'b0, rsp_valid}, 0);
    chk("mid_rst_sticky", {24'b0, sticky_flags}, 0);
    chk("mid_rst_rdy", {30'b0, req_ready}, 0);
    tick;
    tick;
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rdy", {30'b0, req_ready}, 2'b01);
    tick;
    req_valid = 2'b00;
    chk("post_lost", {31'b0, rsp_valid}, 0);
    tick;
    chk("post_vld", {31'b0, rsp_valid}, 1);
    chk("post_id", {31'b0, rsp_id}, 0);
    chk("post_res", {16'b0, rsp_result}, 32'h4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
